// File: rtl/pronoc_pkg.sv
// Shared NoC definitions: flit flag encodings, packetizer FSM states and the
// per-NOC_ID configuration table (flit, payload, VC, buffer and field widths).
package pronoc_pkg;

  localparam logic [1:0] HDR_FLAG    = 2'b10;
  localparam logic [1:0] BODY_FLAG   = 2'b00;
  localparam logic [1:0] TAIL_FLAG   = 2'b01;
  localparam logic [1:0] SINGLE_FLAG = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} pkt_state_e;

  typedef enum logic [3:0] {
    P_FW, P_FPAYW, P_V, P_B, P_EAW, P_DAW, P_DSTPW, P_CW, P_WEIGHTW, P_BEW
  } noc_field_e;

  // Fw = 2 flag bits + V one-hot VC bits + FPAYw payload bits in every configuration.
  function automatic int unsigned noc_param(input int unsigned noc_id, input noc_field_e field);
    logic alt;
    alt = (noc_id == 1);
    case (field)
      P_FW:      return alt ? 64 : 32;
      P_FPAYW:   return alt ? 58 : 28;
      P_V:       return alt ? 4  : 2;
      P_B:       return alt ? 2  : 4;
      P_EAW:     return alt ? 6  : 4;
      P_DAW:     return alt ? 6  : 4;
      P_DSTPW:   return alt ? 4  : 3;
      P_CW:      return alt ? 2  : 1;
      P_WEIGHTW: return 4;
      P_BEW:     return alt ? 4  : 2;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/header_flit_generator.sv
// Combinational header payload formatting: control fields packed from bit 0 upward
// (src, dest, destport, class, weight, byte enable), optional header data above them.
module header_flit_generator #(
  parameter int unsigned FPAYw   = 28,
  parameter int unsigned EAw     = 4,
  parameter int unsigned DAw     = 4,
  parameter int unsigned DSTPw   = 3,
  parameter int unsigned Cw      = 1,
  parameter int unsigned WEIGHTw = 4,
  parameter int unsigned BEw     = 2,
  parameter int unsigned DATA_w  = 0,
  localparam int unsigned HDw    = (DATA_w > 0) ? DATA_w : 1
) (
  input  logic [EAw-1:0]     src_e_addr,
  input  logic [DAw-1:0]     dest_e_addr,
  input  logic [DSTPw-1:0]   destport,
  input  logic [Cw-1:0]      class_in,
  input  logic [WEIGHTw-1:0] weight_in,
  input  logic [BEw-1:0]     be_in,
  input  logic [HDw-1:0]     hdr_data,
  output logic [FPAYw-1:0]   hdr_payload
);

  localparam int unsigned CTRLw = EAw + DAw + DSTPw + Cw + WEIGHTw + BEw;

  logic [CTRLw-1:0] ctrl;
  assign ctrl = {be_in, weight_in, class_in, destport, dest_e_addr, src_e_addr};

  if (DATA_w > 0) begin : g_data
    assign hdr_payload = FPAYw'({hdr_data, ctrl});
  end else begin : g_no_data
    logic unused_hdr_data;
    assign unused_hdr_data = ^hdr_data;
    assign hdr_payload     = FPAYw'(ctrl);
  end

endmodule

// File: rtl/packetizer_credit_counter.sv
// One VC's credit count: starts full at B, -1 per flit sent, +1 per returned credit,
// saturating at both ends; a send and a return in the same cycle cancel.
module packetizer_credit_counter #(
  parameter int unsigned  B    = 4,
  localparam int unsigned CNTw = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTw-1:0] count
);

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= CNTw'(B);
    end else if (inc && !dec) begin
      if (count != CNTw'(B)) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && inc && !dec && count == CNTw'(B))
      $display("ERROR: credit returned to a full counter (saturated at %0d)", B);
`endif

endmodule

// File: rtl/multi_flit_packetizer.sv
// Packet request + payload stream to header/body/tail flits for one router local port,
// gated by per-VC credits. One flit per cycle inside a packet, one idle cycle between packets.
module multi_flit_packetizer
  import pronoc_pkg::*;
#(
  parameter int unsigned  NOC_ID      = 0,
  parameter int unsigned  DATA_w      = 0,
  parameter int unsigned  MAX_PKT_LEN = 16,
  localparam int unsigned Fw      = noc_param(NOC_ID, P_FW),
  localparam int unsigned FPAYw   = noc_param(NOC_ID, P_FPAYW),
  localparam int unsigned V       = noc_param(NOC_ID, P_V),
  localparam int unsigned B       = noc_param(NOC_ID, P_B),
  localparam int unsigned EAw     = noc_param(NOC_ID, P_EAW),
  localparam int unsigned DAw     = noc_param(NOC_ID, P_DAW),
  localparam int unsigned DSTPw   = noc_param(NOC_ID, P_DSTPW),
  localparam int unsigned Cw      = noc_param(NOC_ID, P_CW),
  localparam int unsigned WEIGHTw = noc_param(NOC_ID, P_WEIGHTW),
  localparam int unsigned BEw     = noc_param(NOC_ID, P_BEW),
  localparam int unsigned LENw    = $clog2(MAX_PKT_LEN + 1),
  localparam int unsigned HDw     = (DATA_w > 0) ? DATA_w : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [EAw-1:0]     src_e_addr,
  input  logic [DAw-1:0]     dest_e_addr,
  input  logic [DSTPw-1:0]   destport,
  input  logic [Cw-1:0]      class_in,
  input  logic [WEIGHTw-1:0] weight_in,
  input  logic [BEw-1:0]     be_in,
  input  logic [V-1:0]       vc_num_in,
  input  logic [LENw-1:0]    pkt_len,
  input  logic [HDw-1:0]     hdr_data,
  input  logic               pld_valid,
  output logic               pld_ready,
  input  logic [FPAYw-1:0]   pld_data,
  output logic [Fw-1:0]      flit_out,
  output logic               flit_out_wr,
  input  logic [V-1:0]       credit_in,
  output logic               busy
);

  localparam int unsigned CNTw   = $clog2(B + 1);
  localparam int unsigned BE_LSB = EAw + DAw + DSTPw + Cw + WEIGHTw;

  pkt_state_e       state_q, state_d;
  logic [LENw-1:0]  cnt_q, cnt_d, len_eff;
  logic [V-1:0]     vc_sel_q, vc_req_sel, credit_nz, credit_dec;
  logic [FPAYw-1:0] hdr_pld, hdr_pld_q, tail_pld;
  logic [BEw-1:0]   be_q;
  logic [Fw-1:0]    flit_d;
  logic             send, load, credit_ok;

  header_flit_generator #(
    .FPAYw(FPAYw), .EAw(EAw), .DAw(DAw), .DSTPw(DSTPw), .Cw(Cw),
    .WEIGHTw(WEIGHTw), .BEw(BEw), .DATA_w(DATA_w)
  ) u_hdr_gen (
    .src_e_addr (src_e_addr),
    .dest_e_addr(dest_e_addr),
    .destport   (destport),
    .class_in   (class_in),
    .weight_in  (weight_in),
    .be_in      (be_in),
    .hdr_data   (hdr_data),
    .hdr_payload(hdr_pld)
  );

  for (genvar i = 0; i < V; i++) begin : g_credit
    logic [CNTw-1:0] count;
    packetizer_credit_counter #(.B(B)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (credit_in[i]),
      .dec  (credit_dec[i]),
      .count(count)
    );
    assign credit_nz[i] = (count != '0);
  end

  // Lowest set bit wins; an all-zero request falls back to VC0 rather than deadlocking.
  assign vc_req_sel = (vc_num_in == '0) ? V'(1) : (vc_num_in & (~vc_num_in + 1'b1));
  assign credit_ok  = |(credit_nz & vc_sel_q);
  assign credit_dec = send ? vc_sel_q : '0;
  assign busy       = (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    len_eff = pkt_len;
    if (pkt_len == '0)                      len_eff = LENw'(1);
    else if (pkt_len > LENw'(MAX_PKT_LEN))  len_eff = LENw'(MAX_PKT_LEN);
    tail_pld = pld_data;
    tail_pld[BE_LSB +: BEw] = be_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    pld_ready = 1'b0;
    send      = 1'b0;
    load      = 1'b0;
    flit_d    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load    = 1'b1;
          cnt_d   = len_eff;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (credit_ok) begin
          send = 1'b1;
          if (cnt_q == LENw'(1)) begin
            flit_d  = {SINGLE_FLAG, vc_sel_q, hdr_pld_q};
            state_d = S_IDLE;
          end else begin
            flit_d  = {HDR_FLAG, vc_sel_q, hdr_pld_q};
            cnt_d   = cnt_q - 1'b1;
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        pld_ready = credit_ok;
        if (pld_valid && credit_ok) begin
          send  = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LENw'(1)) begin
            flit_d  = {TAIL_FLAG, vc_sel_q, tail_pld};
            state_d = S_IDLE;
          end else begin
            flit_d  = {BODY_FLAG, vc_sel_q, pld_data};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vc_sel_q    <= V'(1);
      hdr_pld_q   <= '0;
      be_q        <= '0;
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flit_out_wr <= send;
      if (send) flit_out <= flit_d;
      if (load) begin
        vc_sel_q  <= vc_req_sel;
        hdr_pld_q <= hdr_pld;
        be_q      <= be_in;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && req_valid && req_ready && !$onehot(vc_num_in))
      $display("ERROR: multi_flit_packetizer vc_num_in=%b is not one-hot", vc_num_in);
`endif

endmodule

// File: tb/tb_multi_flit_packetizer.sv
// Directed bench for multi_flit_packetizer at NOC_ID 0 (V=2, B=4, Fw=32, FPAYw=28).
module tb_multi_flit_packetizer;
  import pronoc_pkg::*;

  localparam int MAXL = 16;
  // src=3, dest=A, destport=5, class=1, weight=9, be=2'b10 packed from bit 0 upward
  localparam logic [27:0] HDR_PLD = 28'h0029DA3;

  logic        clk = 1'b0, reset;
  logic        req_valid, req_ready, pld_valid, pld_ready, flit_out_wr, busy;
  logic [3:0]  src_e_addr, dest_e_addr, weight_in;
  logic [2:0]  destport;
  logic [0:0]  class_in, hdr_data;
  logic [1:0]  be_in, vc_num_in, credit_in;
  logic [4:0]  pkt_len;
  logic [27:0] pld_data;
  logic [31:0] flit_out;
  int checks = 0, errors = 0;

  multi_flit_packetizer #(.NOC_ID(0), .DATA_w(0), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .src_e_addr(src_e_addr), .dest_e_addr(dest_e_addr), .destport(destport),
    .class_in(class_in), .weight_in(weight_in), .be_in(be_in), .vc_num_in(vc_num_in),
    .pkt_len(pkt_len), .hdr_data(hdr_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .pld_data(pld_data), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
    .credit_in(credit_in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] vc, input logic [4:0] len);
    req_valid = 1'b1; vc_num_in = vc; pkt_len = len;
  endtask

  task automatic give_credit(input logic [1:0] mask, input int n);
    repeat (n) begin credit_in = mask; tick(); end
    credit_in = 2'b00;
  endtask

  function automatic logic [27:0] with_be(input logic [27:0] d);
    logic [27:0] r;
    r = d;
    r[17:16] = 2'b10;
    return r;
  endfunction

  task automatic test_reset();
    checks++; if (flit_out !== 32'h0) begin errors++; $display("FAIL reset_flit: got %h exp 0", flit_out); end
    checks++; if ({flit_out_wr, req_ready, pld_ready, busy} !== 4'b0100) begin errors++;
      $display("FAIL reset_ctrl: got wr/rr/pr/busy=%b exp 0100", {flit_out_wr, req_ready, pld_ready, busy}); end
    checks++; if ({dut.g_credit[1].u_cnt.count, dut.g_credit[0].u_cnt.count} !== {3'd4, 3'd4}) begin errors++;
      $display("FAIL reset_credit: got %0d/%0d exp 4/4", dut.g_credit[1].u_cnt.count, dut.g_credit[0].u_cnt.count); end
  endtask

  task automatic test_single_flit();
    drive_req(2'b01, 5'd1);
    tick();
    req_valid = 1'b0;
    checks++; if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL single_hdr_state: got busy/rr=%b exp 10", {busy, req_ready}); end
    tick();
    checks++; if (flit_out_wr !== 1'b1) begin errors++; $display("FAIL single_wr: got %b exp 1", flit_out_wr); end
    checks++; if (flit_out !== 32'hD0029DA3) begin errors++; $display("FAIL single_flit: got %h exp d0029da3", flit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b exp 0", busy); end
    checks++; if (dut.g_credit[0].u_cnt.count !== 3'd3) begin errors++; $display("FAIL single_credit: got %0d exp 3", dut.g_credit[0].u_cnt.count); end
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b0, 32'hD0029DA3}) begin errors++;
      $display("FAIL single_hold: got wr=%b flit=%h exp wr=0 flit=d0029da3", flit_out_wr, flit_out); end
  endtask

  task automatic test_four_flit();
    logic [27:0] d;
    drive_req(2'b10, 5'd4);
    tick();
    req_valid = 1'b0; pld_valid = 1'b1; pld_data = 28'h0A51000;
    checks++; if (pld_ready !== 1'b0) begin errors++; $display("FAIL four_pr_in_hdr: got %b exp 0", pld_ready); end
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b1, HDR_FLAG, 2'b10, HDR_PLD}) begin errors++;
      $display("FAIL four_hdr: got wr=%b flit=%h exp wr=1 flit=%h", flit_out_wr, flit_out, {HDR_FLAG, 2'b10, HDR_PLD}); end
    for (int i = 0; i < 3; i++) begin
      d = 28'h0A51000 + 28'(i);
      tick();
      pld_data = 28'h0A51000 + 28'(i + 1);
      if (i < 2) begin
        checks++; if ({flit_out_wr, flit_out} !== {1'b1, BODY_FLAG, 2'b10, d}) begin errors++;
          $display("FAIL four_body%0d: got wr=%b flit=%h exp %h", i, flit_out_wr, flit_out, {BODY_FLAG, 2'b10, d}); end
      end else begin
        checks++; if ({flit_out_wr, flit_out} !== {1'b1, TAIL_FLAG, 2'b10, with_be(d)}) begin errors++;
          $display("FAIL four_tail: got wr=%b flit=%h exp %h", flit_out_wr, flit_out, {TAIL_FLAG, 2'b10, with_be(d)}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL four_busy: got %b exp 0", busy); end
      end
    end
    pld_valid = 1'b0;
    checks++; if (dut.g_credit[1].u_cnt.count !== 3'd0) begin errors++; $display("FAIL four_credit: got %0d exp 0", dut.g_credit[1].u_cnt.count); end
    tick();
    checks++; if (flit_out_wr !== 1'b0) begin errors++; $display("FAIL four_wr_after: got %b exp 0", flit_out_wr); end
    give_credit(2'b11, 1);
    give_credit(2'b10, 3);
    checks++; if ({dut.g_credit[1].u_cnt.count, dut.g_credit[0].u_cnt.count} !== {3'd4, 3'd4}) begin errors++;
      $display("FAIL four_restore: got %0d/%0d exp 4/4", dut.g_credit[1].u_cnt.count, dut.g_credit[0].u_cnt.count); end
  endtask

  task automatic test_credit_stall();
    drive_req(2'b01, 5'd6);
    tick();
    req_valid = 1'b0; pld_valid = 1'b1; pld_data = 28'h0300000;
    tick();
    checks++; if ({flit_out_wr, flit_out[31:28]} !== {1'b1, HDR_FLAG, 2'b01}) begin errors++;
      $display("FAIL stall_hdr: got wr=%b top=%h exp wr=1 top=9", flit_out_wr, flit_out[31:28]); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if ({flit_out_wr, flit_out} !== {1'b1, BODY_FLAG, 2'b01, 28'h0300000 + 28'(j)}) begin errors++;
        $display("FAIL stall_body%0d: got wr=%b flit=%h", j, flit_out_wr, flit_out); end
      pld_data = 28'h0300000 + 28'(j + 1);
    end
    checks++; if ({pld_ready, dut.g_credit[0].u_cnt.count} !== {1'b0, 3'd0}) begin errors++;
      $display("FAIL stall_empty: got pr=%b credit=%0d exp pr=0 credit=0", pld_ready, dut.g_credit[0].u_cnt.count); end
    tick();
    checks++; if ({flit_out_wr, busy, pld_ready} !== 3'b010) begin errors++;
      $display("FAIL stall_hold: got wr/busy/pr=%b exp 010", {flit_out_wr, busy, pld_ready}); end
    give_credit(2'b01, 1);
    checks++; if (pld_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_pr: got %b exp 1", pld_ready); end
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b1, BODY_FLAG, 2'b01, 28'h0300003}) begin errors++;
      $display("FAIL stall_body3: got wr=%b flit=%h", flit_out_wr, flit_out); end
    pld_data = 28'h0300004;
    give_credit(2'b01, 1);
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b1, TAIL_FLAG, 2'b01, with_be(28'h0300004)}) begin errors++;
      $display("FAIL stall_tail: got wr=%b flit=%h", flit_out_wr, flit_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy: got %b exp 0", busy); end
    pld_valid = 1'b0;
    give_credit(2'b01, 4);
  endtask

  task automatic test_credit_edges();
    drive_req(2'b01, 5'd1);
    tick();
    req_valid = 1'b0; credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    checks++; if ({flit_out_wr, flit_out[31:30]} !== {1'b1, SINGLE_FLAG}) begin errors++;
      $display("FAIL edge_send: got wr=%b flags=%b exp wr=1 flags=11", flit_out_wr, flit_out[31:30]); end
    checks++; if (dut.g_credit[0].u_cnt.count !== 3'd4) begin errors++; $display("FAIL edge_cancel: got %0d exp 4", dut.g_credit[0].u_cnt.count); end
    give_credit(2'b01, 1);
    checks++; if (dut.g_credit[0].u_cnt.count !== 3'd4) begin errors++; $display("FAIL edge_saturate: got %0d exp 4", dut.g_credit[0].u_cnt.count); end
  endtask

  task automatic test_reset_mid_packet();
    drive_req(2'b10, 5'd8);
    tick();
    req_valid = 1'b0; pld_valid = 1'b1; pld_data = 28'h0777000;
    tick();
    tick();
    checks++; if ({flit_out_wr, flit_out[31:30], dut.g_credit[1].u_cnt.count} !== {1'b1, BODY_FLAG, 3'd2}) begin errors++;
      $display("FAIL rst_pre: got wr=%b flags=%b credit=%0d exp 1/00/2", flit_out_wr, flit_out[31:30], dut.g_credit[1].u_cnt.count); end
    reset = 1'b0;
    tick();
    checks++; if ({flit_out, flit_out_wr, req_ready, pld_ready, busy} !== {32'h0, 4'b0100}) begin errors++;
      $display("FAIL rst_outputs: got flit=%h wr/rr/pr/busy=%b", flit_out, {flit_out_wr, req_ready, pld_ready, busy}); end
    checks++; if (dut.g_credit[1].u_cnt.count !== 3'd4) begin errors++; $display("FAIL rst_credit: got %0d exp 4", dut.g_credit[1].u_cnt.count); end
    reset = 1'b1; pld_valid = 1'b0;
    drive_req(2'b10, 5'd2);
    tick();
    req_valid = 1'b0; pld_valid = 1'b1;
    checks++; if ({busy, flit_out_wr} !== 2'b10) begin errors++; $display("FAIL rst_restart_hdr: got busy/wr=%b exp 10", {busy, flit_out_wr}); end
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b1, HDR_FLAG, 2'b10, HDR_PLD}) begin errors++;
      $display("FAIL rst_restart_flit: got wr=%b flit=%h", flit_out_wr, flit_out); end
    tick();
    checks++; if ({flit_out_wr, flit_out} !== {1'b1, TAIL_FLAG, 2'b10, with_be(28'h0777000)}) begin errors++;
      $display("FAIL rst_restart_tail: got wr=%b flit=%h", flit_out_wr, flit_out); end
    pld_valid = 1'b0;
    give_credit(2'b10, 2);
  endtask

  task automatic test_length_limits();
    drive_req(2'b01, 5'd0);
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if ({flit_out_wr, flit_out[31:30], busy} !== {1'b1, SINGLE_FLAG, 1'b0}) begin errors++;
      $display("FAIL len0: got wr=%b flags=%b busy=%b exp 1/11/0", flit_out_wr, flit_out[31:30], busy); end
    drive_req(2'b10, 5'(MAXL + 3));
    pld_valid = 1'b1;
    tick();
    req_valid = 1'b0; credit_in = 2'b10;
    for (int i = 0; i < MAXL; i++) begin
      pld_data = 28'h0100000 + 28'(i);
      tick();
      checks++;
      if ({flit_out_wr, flit_out[31:28]} !== {1'b1, (i == 0) ? HDR_FLAG : (i == MAXL - 1) ? TAIL_FLAG : BODY_FLAG, 2'b10}) begin
        errors++; $display("FAIL lenmax_flit%0d: got wr=%b top=%h", i, flit_out_wr, flit_out[31:28]);
      end
    end
    credit_in = 2'b00; pld_valid = 1'b0;
    checks++; if ({busy, dut.g_credit[1].u_cnt.count} !== {1'b0, 3'd4}) begin errors++;
      $display("FAIL lenmax_end: got busy=%b credit=%0d exp 0/4", busy, dut.g_credit[1].u_cnt.count); end
    tick();
    checks++; if (flit_out_wr !== 1'b0) begin errors++; $display("FAIL lenmax_extra: got wr=%b exp 0", flit_out_wr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wr_seq;
    drive_req(2'b01, 5'd1);
    tick();
    wr_seq[3] = flit_out_wr;
    tick();
    wr_seq[2] = flit_out_wr;
    tick();
    wr_seq[1] = flit_out_wr;
    req_valid = 1'b0;
    tick();
    wr_seq[0] = flit_out_wr;
    checks++; if (wr_seq !== 4'b0101) begin errors++; $display("FAIL b2b_bubble: got wr pattern %b exp 0101", wr_seq); end
    checks++; if (dut.g_credit[0].u_cnt.count !== 3'd1) begin errors++; $display("FAIL b2b_credit: got %0d exp 1", dut.g_credit[0].u_cnt.count); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; pld_valid = 1'b0; credit_in = 2'b00;
    src_e_addr = 4'h3; dest_e_addr = 4'hA; destport = 3'h5; class_in = 1'b1;
    weight_in = 4'h9; be_in = 2'b10; hdr_data = 1'b0; vc_num_in = 2'b01;
    pkt_len = 5'd1; pld_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    test_reset();
    test_single_flit();
    test_four_flit();
    test_credit_stall();
    test_credit_edges();
    test_reset_mid_packet();
    test_length_limits();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
